fpadd_stream_ctrl: RTL and testbench
====================================

# fpadd_stream_ctrl

- Sits in front of `fpadd_pipelined` and gives the free-running adder a valid/ready streaming front end.
- Accepts FP32 operand pairs from an upstream producer through a valid/ready handshake and drives them onto the adder's operand inputs.
- Tracks each accepted pair through the adder's fixed latency and captures the matching sum into an internal FIFO.
- Returns sums in order to a downstream consumer through a second valid/ready handshake, with credit-based flow control so no result is ever lost.

## Interface

Parameters:
- LATENCY, 2, cycles from an operand-sampling edge to the edge where the adder output is valid; must equal the adder's latency.
- DEPTH, 4, result FIFO entries; power of two, DEPTH ≥ LATENCY+2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_a  in  32  FP32 operand A.
- in_b  in  32  FP32 operand B.
- add_a  out  32  to adder reg_A.
- add_b  out  32  to adder reg_B.
- add_out  in  32  from adder out.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  FP32 sum at FIFO head.
- busy  out  1  any pair in flight or any result buffered.

## Operation

- The handshake rule is the same on both ports: a transfer happens on any posedge with valid && ready.
- Operand path:
  - add_a = in_a and add_b = in_b, combinational pass-through; the adder registers them itself.
  - Operand values are don't-care when no transfer happens.
- Tag pipeline:
  - tag[LATENCY-1:0] is a shift register.
  - On each edge: tag[0] <= input transfer, and tag[i] <= tag[i-1].
  - inflight = popcount(tag).
- Capture:
  - On an edge with tag[LATENCY-1]=1, add_out is pushed into the FIFO.
  - The push is unconditional; credit flow control guarantees space.
- Credit: in_ready = !reset && (count + inflight < DEPTH).
  - There is deliberately no credit for a same-cycle pop, so there is no combinational path from out_ready to in_ready.
- FIFO behaviour:
  - First-word fall-through: out_data = mem[rd_ptr], and out_valid = (count != 0).
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Pop when empty is impossible, because out_valid=0.
- Results leave strictly in acceptance order. No arithmetic is performed here, and the adder's zero and sign handling pass through untouched.
- busy = (inflight != 0) || (count != 0).
- Reset, including mid-operation:
  - tag, pointers and count clear to 0, and out_valid = 0.
  - in_ready is 0 while reset is asserted, and 1 on the first cycle after release.
  - busy = 0.
  - Pairs in flight are dropped. FIFO contents are discarded; mem is not cleared.
  - The adder's own stale output is ignored, because no tag is set.

## Timing

- Pair accepted at edge k → tag[LATENCY-1] high on edge k+LATENCY-1 → pushed at edge k+LATENCY.
- out_valid rises after edge k+LATENCY, i.e. 2 cycles at default.
- Full throughput is one pair per cycle while out_ready=1. At steady state, inflight=2 and count=1, giving 3 < 4.
- With out_ready=0, at most DEPTH pairs are accepted. in_ready falls on the cycle after the DEPTH-th accept.
- Every output is a function of registers and reset only. The exceptions are add_a and add_b, which are combinational from in_a and in_b.

## Structure

- Shared package `fpadd_pkg`:
  - FP32 field widths and positions: sign 31, exponent 30:23, mantissa 22:0, exponent bias 127.
  - FPADD_LATENCY=2, used as the LATENCY default by both the adder wrapper and this block.
- Sub-module `sync_fifo_fwft`:
  - Parameters WIDTH and DEPTH.
  - Ports push, push_data, pop, head_data, count, empty.
  - Same clk and reset.
- The top level holds the tag pipeline, credit logic and output mapping.

## Test plan

- **Single add:** in_a=0x3F800000 (1.0), in_b=0x40000000 (2.0), out_ready=1 → out_valid 2 cycles after accept, out_data=0x40400000 (3.0).
- **Zero result:** 0x3FC00000 + 0xBFC00000 (1.5 + −1.5) → out_data=0x00000000 with sign bit 0.
- **Streaming:** 8 back-to-back pairs with in_valid=1 and out_ready=1 → in_ready never drops, 8 results arrive on consecutive cycles in order, and busy=0 two cycles after the last result.
- **Backpressure:** out_ready=0 while 6 pairs are offered → exactly 4 accepted, in_ready=0 after the 4th. Then out_ready=1 → 4 results in order, followed by acceptance of the remaining 2.
- **Simultaneous push/pop:** with the FIFO at count=DEPTH-1 and out_ready toggling every cycle → count never exceeds DEPTH, and no result is duplicated or lost.
- **Reset mid-operation:** assert reset with 2 pairs in flight and 2 buffered → out_valid=0 and busy=0 immediately. After release, no stale result appears, and a new pair 0x40800000 + 0x40800000 yields 0x41000000.

Source files
------------

// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - FP32 field layout and adder latency shared by the adder wrapper and its stream front end
package fpadd_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MANT_MSB = 22;
  localparam int FP_MANT_LSB = 0;
  localparam int FP_EXP_BIAS = 127;

  localparam int FPADD_LATENCY = 2;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word fall-through FIFO; head_data is valid whenever empty is low
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;

  // Pointers are exactly log2(DEPTH) wide so they wrap without a compare.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/fpadd_stream_ctrl.sv
// rtl/fpadd_stream_ctrl.sv - valid/ready front end for the free-running pipelined FP32 adder
module fpadd_stream_ctrl
  import fpadd_pkg::*;
#(
  parameter int LATENCY = FPADD_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_a,
  input  logic [FP_WIDTH-1:0] in_b,
  output logic [FP_WIDTH-1:0] add_a,
  output logic [FP_WIDTH-1:0] add_b,
  input  logic [FP_WIDTH-1:0] add_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_data,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [AW:0]        fifo_count;
  logic               fifo_empty;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      credit_used;
  logic               in_xfer;
  logic               pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
    credit_used = CW'(fifo_count) + inflight;
  end

  // Every accepted pair reserves a FIFO slot up front; a same-cycle pop is
  // not credited so out_ready never reaches in_ready combinationally.
  assign in_ready = !reset && (credit_used < CW'(DEPTH));
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    tag_d    = '0;
    tag_d[0] = in_xfer;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign add_a = in_a;
  assign add_b = in_b;

  sync_fifo_fwft #(
    .WIDTH(FP_WIDTH),
    .DEPTH(DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tag_q[LATENCY-1]),
    .push_data(add_out),
    .pop      (pop),
    .head_data(out_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// tb/tb_fpadd_stream_ctrl.sv - directed and randomized checks of fpadd_stream_ctrl against a queue model
module tb_fpadd_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] add_a, add_b, out_data;
  logic [31:0] add_out, a_r, b_r;
  logic        in_ready, out_valid, busy;

  typedef struct { logic [31:0] sum; int rdy; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
  exp_t  q[$];
  pair_t src[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  fpadd_stream_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_out  (add_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  function automatic real fp2r(logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2fp(real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  function automatic logic [31:0] int2fp(int n);
    return r2fp(real'(n));
  endfunction

  // Stand-in for fpadd_pipelined: operand registers then an output register.
  always @(posedge clk) begin
    a_r     <= add_a;
    b_r     <= add_b;
    add_out <= fadd(a_r, b_r);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic exp_ir, exp_ov, ixf, oxf;
    #1;
    exp_ir = !reset && (q.size() < DEPTH);
    exp_ov = 1'b0;
    if (!reset && q.size() > 0) exp_ov = (cyc >= q[0].rdy);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("busy", 32'(busy), 32'(q.size() != 0));
    if (exp_ov) check("out_data", out_data, q[0].sum);
    if (in_valid) begin
      check("add_a", add_a, in_a);
      check("add_b", add_b, in_b);
    end
    ixf = in_valid && exp_ir;
    oxf = exp_ov && out_ready;
    @(posedge clk);
    cyc++;
    if (oxf) void'(q.pop_front());
    if (ixf) begin
      q.push_back('{fadd(in_a, in_b), cyc + LAT});
      accepted++;
    end
    @(negedge clk);
  endtask

  task automatic pump(int n, int vp, int rp);
    int acc0;
    repeat (n) begin
      in_valid = (src.size() > 0) && ($urandom_range(99) < vp);
      if (src.size() > 0) begin
        in_a = src[0].a;
        in_b = src[0].b;
      end else begin
        in_a = $urandom;
        in_b = $urandom;
      end
      out_ready = ($urandom_range(99) < rp);
      acc0 = accepted;
      tick();
      if (accepted != acc0) void'(src.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((src.size() > 0 || q.size() > 0) && n < bound) begin
      pump(1, 100, 100);
      n++;
    end
    tick();
    check("drain_idle_busy", 32'(busy), 32'd0);
  endtask

  function automatic pair_t rnd_pair();
    pair_t p;
    p.a = int2fp(int'($urandom_range(1000)) - 500);
    p.b = int2fp(int'($urandom_range(1000)) - 500);
    return p;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // single add, latency 2
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("single_early", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sum", out_data, 32'h40400000);
    tick();

    // zero result keeps sign bit clear
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'hBFC00000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("zero_sum", out_data, 32'h00000000);
    tick();

    // streaming, 8 back-to-back
    for (int i = 0; i < 8; i++) src.push_back(rnd_pair());
    drain(30);

    // backpressure: 6 offered, 4 taken
    for (int i = 0; i < 6; i++) src.push_back('{int2fp(i + 1), int2fp(10 * i)});
    pump(6, 100, 0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_head", out_data, int2fp(1));
    drain(30);

    // push and pop together with FIFO near full
    for (int i = 0; i < 3; i++) src.push_back(rnd_pair());
    pump(3, 100, 0);
    pump(2, 0, 0);
    for (int i = 0; i < 16; i++) src.push_back(rnd_pair());
    for (int i = 0; i < 20; i++) pump(1, 100, (i % 2 == 1) ? 100 : 0);
    drain(40);

    // randomized traffic
    for (int i = 0; i < 150; i++) src.push_back(rnd_pair());
    pump(250, 70, 60);
    drain(80);

    // reset with two in flight and two buffered
    for (int i = 0; i < 4; i++) src.push_back(rnd_pair());
    pump(4, 100, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    src.delete();
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    pump(4, 0, 100);
    in_valid = 1'b1; in_a = 32'h40800000; in_b = 32'h40800000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_sum", out_data, 32'h41000000);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
